// File: rtl/wshb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wshb_arb_pkg
// Description : Shared types and default sizes for the two-master Wishbone
//               arbiter and its helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package wshb_arb_pkg;

   // Arbiter grant state; owner output is decoded directly from this.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_t;

   localparam int DEF_AW      = 32;
   localparam int DEF_DW      = 32;
   localparam int DEF_TIMEOUT = 255;
   localparam int DEF_CNT_W   = 16;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at its all-ones value instead of
//               wrapping. Synchronous active-low clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
   import wshb_arb_pkg::*;
#(
   parameter int W = DEF_CNT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] q
);

   localparam logic [W-1:0] MAX_VAL = '1;

   // Count requested events, holding at the maximum once reached.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= '0;
      end else if (inc && (q != MAX_VAL)) begin
         q <= q + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/wshb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wshb_arbiter
// Description : Two-master / one-slave classic Wishbone arbiter. Round-robin
//               on ties, bus locked while the owner holds cyc, per-grant ack
//               timeout with an err pulse, saturating per-master ack counters.
// Revision    : 1.0 - initial release
// ============================================================================
module wshb_arbiter
   import wshb_arb_pkg::*;
#(
   parameter int AW      = DEF_AW,
   parameter int DW      = DEF_DW,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   // master 0 (framebuffer reader)
   input  logic              m0_cyc,
   input  logic              m0_stb,
   input  logic              m0_we,
   input  logic [AW-1:0]     m0_adr,
   input  logic [DW-1:0]     m0_dat_w,
   input  logic [DW/8-1:0]   m0_sel,
   output logic              m0_ack,
   output logic              m0_err,
   output logic [DW-1:0]     m0_dat_r,
   // master 1 (pixel writer / host bridge)
   input  logic              m1_cyc,
   input  logic              m1_stb,
   input  logic              m1_we,
   input  logic [AW-1:0]     m1_adr,
   input  logic [DW-1:0]     m1_dat_w,
   input  logic [DW/8-1:0]   m1_sel,
   output logic              m1_ack,
   output logic              m1_err,
   output logic [DW-1:0]     m1_dat_r,
   // shared slave
   output logic              s_cyc,
   output logic              s_stb,
   output logic              s_we,
   output logic [AW-1:0]     s_adr,
   output logic [DW-1:0]     s_dat_w,
   output logic [DW/8-1:0]   s_sel,
   input  logic              s_ack,
   input  logic [DW-1:0]     s_dat_r,
   // debug
   output logic [1:0]        owner,
   output logic [CNT_W-1:0]  ack_cnt0,
   output logic [CNT_W-1:0]  ack_cnt1
);

   // Timer only needs to reach TIMEOUT-1: the stall that would take it to
   // TIMEOUT is the timeout cycle itself, and that cycle always clears it.
   localparam int             TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

   arb_state_t    state, state_nxt;
   logic          last_served, last_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic          gnt0, gnt1;
   logic          own_stb;
   logic          timeout;

   // Grants are masked by reset so nothing reaches either side in a reset cycle.
   assign gnt0    = rst_n && (state == GNT0);
   assign gnt1    = rst_n && (state == GNT1);
   assign owner   = {gnt1, gnt0};
   assign own_stb = (gnt0 && m0_stb) || (gnt1 && m1_stb);

   // An ack in the would-be timeout cycle wins, hence the !s_ack term.
   assign timeout = own_stb && !s_ack && (timer == TMO_LAST);

   // Slave-side mux from the current owner; cyc/stb drop in the timeout cycle.
   always_comb begin
      s_cyc   = 1'b0;
      s_stb   = 1'b0;
      s_we    = 1'b0;
      s_adr   = '0;
      s_dat_w = '0;
      s_sel   = '0;
      if (gnt0) begin
         s_cyc   = m0_cyc && !timeout;
         s_stb   = m0_stb && !timeout;
         s_we    = m0_we;
         s_adr   = m0_adr;
         s_dat_w = m0_dat_w;
         s_sel   = m0_sel;
      end else if (gnt1) begin
         s_cyc   = m1_cyc && !timeout;
         s_stb   = m1_stb && !timeout;
         s_we    = m1_we;
         s_adr   = m1_adr;
         s_dat_w = m1_dat_w;
         s_sel   = m1_sel;
      end
   end

   // Master-side return path; the non-owner sees all zeros.
   always_comb begin
      m0_ack   = gnt0 && s_ack && m0_stb;
      m1_ack   = gnt1 && s_ack && m1_stb;
      m0_err   = gnt0 && timeout;
      m1_err   = gnt1 && timeout;
      m0_dat_r = gnt0 ? s_dat_r : '0;
      m1_dat_r = gnt1 ? s_dat_r : '0;
   end

   // Next grant: round-robin on ties, direct handover on release or timeout.
   always_comb begin
      state_nxt = state;
      last_nxt  = last_served;
      case (state)
         IDLE: begin
            if (m0_cyc && m1_cyc) begin
               state_nxt = last_served ? GNT0 : GNT1;
            end else if (m0_cyc) begin
               state_nxt = GNT0;
            end else if (m1_cyc) begin
               state_nxt = GNT1;
            end
         end
         GNT0: begin
            if (!m0_cyc || timeout) begin
               last_nxt  = 1'b0;
               state_nxt = m1_cyc ? GNT1 : IDLE;
            end
         end
         GNT1: begin
            if (!m1_cyc || timeout) begin
               last_nxt  = 1'b1;
               state_nxt = m0_cyc ? GNT0 : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Stall timer: cleared on every new grant and every ack, counts strobed cycles.
   always_comb begin
      if ((state == IDLE) || (state_nxt != state) || s_ack) begin
         timer_nxt = '0;
      end else if (own_stb) begin
         timer_nxt = timer + 1'b1;
      end else begin
         timer_nxt = timer;
      end
   end

   // Arbiter state registers; master 0 wins the first tie after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_served <= 1'b1;
         timer       <= '0;
      end else begin
         state       <= state_nxt;
         last_served <= last_nxt;
         timer       <= timer_nxt;
      end
   end

   sat_counter #(.W(CNT_W)) u_cnt0 (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (m0_ack),
      .q     (ack_cnt0)
   );

   sat_counter #(.W(CNT_W)) u_cnt1 (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (m1_ack),
      .q     (ack_cnt1)
   );

endmodule
`default_nettype wire

// File: tb/tb_wshb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wshb_arbiter
// Description : Directed self-checking bench for wshb_arbiter
//               (TIMEOUT=8, CNT_W=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wshb_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;
   localparam int CW = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [AW-1:0]   m0_adr, m1_adr, s_adr;
   logic [DW-1:0]   m0_dat_w, m1_dat_w, s_dat_w, m0_dat_r, m1_dat_r, s_dat_r;
   logic [DW/8-1:0] m0_sel, m1_sel, s_sel;
   logic            m0_ack, m0_err, m1_ack, m1_err;
   logic            s_cyc, s_stb, s_we, s_ack;
   logic [1:0]      owner;
   logic [CW-1:0]   ack_cnt0, ack_cnt1;

   int n_checks = 0;
   int n_fail   = 0;

   wshb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
      .m0_dat_w(m0_dat_w), .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_err(m0_err),
      .m0_dat_r(m0_dat_r),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
      .m1_dat_w(m1_dat_w), .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_err(m1_err),
      .m1_dat_r(m1_dat_r),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
      .s_dat_w(s_dat_w), .s_sel(s_sel), .s_ack(s_ack), .s_dat_r(s_dat_r),
      .owner(owner), .ack_cnt0(ack_cnt0), .ack_cnt1(ack_cnt1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_w = '0; m0_sel = '0;
      m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_w = '0; m1_sel = '0;
      s_ack = 0; s_dat_r = '0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      clear_inputs();
      tick();
      tick();
      rst_n = 1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- reset with both masters requesting ----------------
      clear_inputs();
      rst_n = 0;
      m0_cyc = 1; m1_cyc = 1; m0_stb = 1; s_ack = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_owner", owner, 2'b00);
         chk("rst_s_cyc", s_cyc, 0);
         chk("rst_m0_ack", m0_ack, 0);
         chk("rst_cnt0", ack_cnt0, 0);
         chk("rst_cnt1", ack_cnt1, 0);
      end
      s_ack = 0; m0_stb = 0; rst_n = 1;
      #1;
      chk("rel_owner_idle", owner, 2'b00);
      tick();
      chk("rel_owner_m0", owner, 2'b01);
      chk("rel_s_cyc", s_cyc, 1);

      // ---------------- single master, four writes ----------------
      do_reset();
      m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF; m0_adr = 32'h10;
      #1;
      chk("sm_latency_owner", owner, 2'b00);
      chk("sm_latency_s_cyc", s_cyc, 0);
      tick();
      for (int i = 0; i < 4; i++) begin
         m0_adr   = 32'h10 + 32'(4 * i);
         m0_dat_w = 32'hA000 + 32'(i);
         s_ack    = 1;
         s_dat_r  = 32'hCAFE0000 + 32'(i);
         #1;
         chk("sm_s_adr", s_adr, 32'h10 + 4 * i);
         chk("sm_s_dat_w", s_dat_w, 32'hA000 + i);
         chk("sm_s_we", s_we, 1);
         chk("sm_m0_ack", m0_ack, 1);
         chk("sm_m1_ack", m1_ack, 0);
         chk("sm_m0_dat_r", m0_dat_r, 32'hCAFE0000 + i);
         chk("sm_m1_dat_r", m1_dat_r, 0);
         chk("sm_cnt0_run", ack_cnt0, i);
         tick();
      end
      m0_cyc = 0; m0_stb = 0; s_ack = 0;
      #1;
      chk("sm_cnt0_final", ack_cnt0, 4);
      chk("sm_cnt1_final", ack_cnt1, 0);
      tick();
      chk("sm_idle_owner", owner, 2'b00);
      chk("sm_idle_s_cyc", s_cyc, 0);
      chk("sm_idle_s_adr", s_adr, 0);

      // ---------------- contention ----------------
      do_reset();
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100;
      m1_cyc = 1; m1_stb = 1; m1_adr = 32'h200;
      #1;
      chk("ct_idle", owner, 2'b00);
      tick();
      s_ack = 1;
      #1;
      chk("ct_first_owner", owner, 2'b01);
      chk("ct_s_adr_m0", s_adr, 32'h100);
      chk("ct_m0_ack1", m0_ack, 1);
      chk("ct_m1_ack_blocked", m1_ack, 0);
      tick();
      chk("ct_m0_ack2", m0_ack, 1);
      tick();
      m0_cyc = 0; m0_stb = 0; s_ack = 0;
      #1;
      chk("ct_drop_owner", owner, 2'b01);
      chk("ct_drop_s_cyc", s_cyc, 0);
      tick();
      chk("ct_handover_owner", owner, 2'b10);
      chk("ct_handover_s_cyc", s_cyc, 1);
      chk("ct_handover_s_adr", s_adr, 32'h200);
      // m0 re-requests straight away; m1 keeps the bus until it releases
      m0_cyc = 1; m0_stb = 1; s_ack = 1;
      #1;
      chk("ct_m1_ack1", m1_ack, 1);
      chk("ct_m0_ack_blocked", m0_ack, 0);
      tick();
      chk("ct_m1_ack2", m1_ack, 1);
      chk("ct_owner_locked", owner, 2'b10);
      tick();
      m1_cyc = 0; m1_stb = 0; s_ack = 0;
      #1;
      chk("ct_cnt0", ack_cnt0, 2);
      chk("ct_cnt1", ack_cnt1, 2);
      tick();
      chk("ct_back_to_m0", owner, 2'b01);
      // m0 releases, then a tie: m1 wins since m0 was served last
      m0_cyc = 0; m0_stb = 0;
      tick();
      chk("ct_idle2", owner, 2'b00);
      m0_cyc = 1; m1_cyc = 1;
      tick();
      chk("ct_tie_rr_m1", owner, 2'b10);

      // ---------------- timeout ----------------
      do_reset();
      m1_cyc = 1; m1_stb = 1; m1_adr = 32'h300;
      tick();
      m0_cyc = 1; m0_stb = 1;
      #1;
      for (int k = 1; k <= TO; k++) begin
         chk("to_owner", owner, 2'b10);
         chk("to_m1_err", m1_err, (k == TO) ? 1 : 0);
         chk("to_s_cyc", s_cyc, (k == TO) ? 0 : 1);
         chk("to_m0_err", m0_err, 0);
         if (k < TO) tick();
      end
      tick();
      chk("to_handover_owner", owner, 2'b01);
      chk("to_handover_s_cyc", s_cyc, 1);
      chk("to_m1_err_cleared", m1_err, 0);
      // m1 still holds cyc, so it is re-granted once m0 lets go
      m0_cyc = 0; m0_stb = 0;
      tick();
      chk("to_regrant_m1", owner, 2'b10);

      // ---------------- ack vs timeout race ----------------
      for (int k = 1; k < TO; k++) begin
         chk("race_no_err", m1_err, 0);
         tick();
      end
      s_ack = 1;
      #1;
      chk("race_ack", m1_ack, 1);
      chk("race_err", m1_err, 0);
      chk("race_s_cyc", s_cyc, 1);
      tick();
      s_ack = 0;
      #1;
      chk("race_owner_kept", owner, 2'b10);
      chk("race_err_after", m1_err, 0);

      // ---------------- counter saturation, reset mid-burst ----------------
      do_reset();
      m0_cyc = 1; m0_stb = 1;
      tick();
      s_ack = 1;
      #1;
      for (int i = 0; i < 10; i++) begin
         chk("sat_m0_ack", m0_ack, 1);
         chk("sat_cnt_run", ack_cnt0, (i < 7) ? i : 7);
         tick();
      end
      chk("sat_cnt_final", ack_cnt0, 7);
      rst_n = 0;
      #1;
      chk("rstmid_m0_ack", m0_ack, 0);
      chk("rstmid_owner", owner, 2'b00);
      chk("rstmid_s_cyc", s_cyc, 0);
      tick();
      chk("rstmid_cnt0", ack_cnt0, 0);
      chk("rstmid_cnt1", ack_cnt1, 0);
      rst_n = 1;
      clear_inputs();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
